// File: rtl/cic_interp_sequencer.sv
// rtl/cic_interp_sequencer.sv - phase sequencer for a CIC interpolator (comb/integrator strobes)
//
// Purpose:
//   Accepts one input sample per R output phases, strobes the comb section on
//   accept, and strobes the integrator chain once per phase. During phases
//   other than 0 it tells the integrator input mux to select zero.
//   Backpressure from downstream stalls the phase counter.
//
// Optional feature (macro CIC_SEQ_UNDERRUN_EN):
//   Adds a sticky underrun flag and a saturating 16-bit underrun counter. An
//   underrun is the last phase of a sample completing without a new sample
//   arriving to take its place.
//
// Ports:
//   i_clock          rising-edge clock
//   i_reset_n        asynchronous active-low reset
//   i_rate           interpolation ratio R (0 behaves as 1), sampled on accept
//   i_in_valid       upstream sample available
//   o_in_ready       sample accepted when high together with i_in_valid
//   o_comb_en        comb advance strobe (high on the accept cycle)
//   o_integ_en       integrator advance strobe
//   o_zero_stuff     integrator input selects zero instead of comb output
//   o_out_valid      integrator output holds an untaken sample
//   i_out_ready      downstream takes the integrator output
//   o_phase          current phase 0..R-1
//   o_underrun       (CIC_SEQ_UNDERRUN_EN) sticky underrun flag
//   o_underrun_count (CIC_SEQ_UNDERRUN_EN) saturating underrun count
//   o_busy           sample in flight or output not yet taken

module cic_interp_sequencer #(
  parameter int RATE_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic [RATE_WIDTH-1:0] i_rate,
  input  logic                  i_in_valid,
  output logic                  o_in_ready,
  output logic                  o_comb_en,
  output logic                  o_integ_en,
  output logic                  o_zero_stuff,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [RATE_WIDTH-1:0] o_phase,
`ifdef CIC_SEQ_UNDERRUN_EN
  output logic                  o_underrun,
  output logic [15:0]           o_underrun_count,
`endif
  output logic                  o_busy
);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  localparam logic [RATE_WIDTH-1:0] ONE = RATE_WIDTH'(1);

  state_t                state;
  logic [RATE_WIDTH-1:0] phase;
  logic [RATE_WIDTH-1:0] rate_l;
  logic                  out_valid;

  logic slot_ok;
  logic is_run;
  logic last_phase;
  logic in_ready;
  logic accept;
  logic integ_en;

  // The integrator may only advance when its output register is free or
  // being drained this cycle.
  assign slot_ok    = !out_valid || i_out_ready;
  assign is_run     = (state == ST_RUN);
  assign last_phase = (phase == rate_l - ONE);

  // Gating with i_reset_n keeps every strobe low for the whole time reset is
  // held, including the IDLE state where slot_ok would otherwise be high.
  assign in_ready = i_reset_n && slot_ok && (!is_run || last_phase);
  assign accept   = i_in_valid && in_ready;
  assign integ_en = i_reset_n && is_run && slot_ok;

  assign o_in_ready   = in_ready;
  assign o_comb_en    = accept;
  assign o_integ_en   = integ_en;
  assign o_zero_stuff = integ_en && (phase != '0);
  assign o_out_valid  = out_valid;
  assign o_phase      = phase;
  assign o_busy       = is_run || out_valid;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      phase     <= '0;
      rate_l    <= ONE;
      out_valid <= 1'b0;
    end else begin
      // An accept on the last phase takes priority: the next sample starts
      // at phase 0 back-to-back with no idle cycle.
      if (accept) begin
        state  <= ST_RUN;
        phase  <= '0;
        rate_l <= (i_rate == '0) ? ONE : i_rate;
      end else if (integ_en) begin
        if (!last_phase) begin
          phase <= phase + ONE;
        end else begin
          state <= ST_IDLE;
          phase <= '0;
        end
      end

      if (integ_en) begin
        out_valid <= 1'b1;
      end else if (i_out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef CIC_SEQ_UNDERRUN_EN
  logic underrun_evt;

  assign underrun_evt = integ_en && last_phase && !accept;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_underrun       <= 1'b0;
      o_underrun_count <= '0;
    end else if (underrun_evt) begin
      o_underrun <= 1'b1;
      if (o_underrun_count != 16'hFFFF) begin
        o_underrun_count <= o_underrun_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cic_interp_sequencer.sv
// tb/tb_cic_interp_sequencer.sv - directed self-checking bench for cic_interp_sequencer

`timescale 1ns/1ps

module tb_cic_interp_sequencer;

    logic       i_clock;
    logic       i_reset_n;
    logic [7:0] i_rate;
    logic       i_in_valid;
    logic       o_in_ready;
    logic       o_comb_en;
    logic       o_integ_en;
    logic       o_zero_stuff;
    logic       o_out_valid;
    logic       i_out_ready;
    logic [7:0] o_phase;
    logic       o_busy;
`ifdef CIC_SEQ_UNDERRUN_EN
    logic        o_underrun;
    logic [15:0] o_underrun_count;
`endif

    int checks   = 0;
    int failures = 0;

    cic_interp_sequencer #(.RATE_WIDTH(8)) dut (
        .i_clock      (i_clock),
        .i_reset_n    (i_reset_n),
        .i_rate       (i_rate),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .o_comb_en    (o_comb_en),
        .o_integ_en   (o_integ_en),
        .o_zero_stuff (o_zero_stuff),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_phase      (o_phase),
`ifdef CIC_SEQ_UNDERRUN_EN
        .o_underrun       (o_underrun),
        .o_underrun_count (o_underrun_count),
`endif
        .o_busy       (o_busy)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $error("FAIL %s", tag);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        i_in_valid = 1'b0;
        #1;
        while (o_busy === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, o_busy === 1'b0);
    endtask

    int strobes;

    initial begin
        i_reset_n   = 1'b0;
        i_rate      = 8'd4;
        i_in_valid  = 1'b1;
        i_out_ready = 1'b1;
        #12;

        chk("rst_in_ready", o_in_ready === 1'b0);
        chk("rst_comb_en", o_comb_en === 1'b0);
        chk("rst_integ_en", o_integ_en === 1'b0);
        chk("rst_busy", o_busy === 1'b0);
        chk("rst_out_valid", o_out_valid === 1'b0);
        chk("rst_phase", o_phase === 8'd0);

        tick();
        i_reset_n  = 1'b1;
        i_in_valid = 1'b0;
        tick();

        i_rate     = 8'd4;
        i_in_valid = 1'b1;
        #1;
        chk("r4_accept_ready", o_in_ready === 1'b1);
        chk("r4_comb_en", o_comb_en === 1'b1);
        chk("r4_no_integ_at_t", o_integ_en === 1'b0);
        tick();
        i_in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("r4_integ", o_integ_en === 1'b1);
            chk("r4_zero_stuff", o_zero_stuff === (k != 0));
            chk("r4_phase", o_phase === 8'(k));
            chk("r4_comb_quiet", o_comb_en === 1'b0);
            tick();
        end
        #1;
        chk("r4_idle_integ", o_integ_en === 1'b0);
        chk("r4_idle_zs", o_zero_stuff === 1'b0);
        chk("r4_idle_ready", o_in_ready === 1'b1);
        chk("r4_idle_out_valid", o_out_valid === 1'b1);
        tick();
        chk("r4_busy_clear", o_busy === 1'b0);

        i_rate     = 8'd3;
        i_in_valid = 1'b1;
        #1;
        chk("r3_first_accept", o_comb_en === 1'b1);
        tick();
        for (int i = 0; i < 30; i++) begin
            #1;
            chk("r3_integ", o_integ_en === 1'b1);
            chk("r3_phase", o_phase === 8'(i % 3));
            chk("r3_in_ready", o_in_ready === (i % 3 == 2));
            chk("r3_zero_stuff", o_zero_stuff === (i % 3 != 0));
            tick();
        end
        drain("r3_drain");

        tick();
        i_rate     = 8'd4;
        i_in_valid = 1'b1;
        strobes    = 0;
        #1;
        chk("stall_accept", o_comb_en === 1'b1);
        tick();
        i_in_valid = 1'b0;
        #1;
        chk("stall_ph0", o_phase === 8'd0);
        if (o_integ_en === 1'b1) strobes++;
        tick();
        i_out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_phase_hold", o_phase === 8'd1);
            chk("stall_out_valid", o_out_valid === 1'b1);
            chk("stall_no_integ", o_integ_en === 1'b0);
            if (o_integ_en === 1'b1) strobes++;
            tick();
        end
        i_out_ready = 1'b1;
        for (int p = 1; p < 4; p++) begin
            #1;
            chk("resume_phase", o_phase === 8'(p));
            chk("resume_integ", o_integ_en === 1'b1);
            if (o_integ_en === 1'b1) strobes++;
            tick();
        end
        #1;
        if (o_integ_en === 1'b1) strobes++;
        chk("stall_strobe_count", strobes == 4);
        drain("stall_drain");

        tick();
        i_rate     = 8'd4;
        i_in_valid = 1'b1;
        #1;
        chk("rc_accept4", o_comb_en === 1'b1);
        tick();
        i_in_valid = 1'b0;
        i_rate     = 8'd2;
        for (int p = 0; p < 3; p++) begin
            #1;
            chk("rc_phase4", o_phase === 8'(p));
            chk("rc_ready4", o_in_ready === 1'b0);
            tick();
        end
        i_in_valid = 1'b1;
        #1;
        chk("rc_phase3", o_phase === 8'd3);
        chk("rc_accept2", o_comb_en === 1'b1);
        chk("rc_integ3", o_integ_en === 1'b1);
        tick();
        i_in_valid = 1'b0;
        #1;
        chk("rc2_ph0", o_phase === 8'd0);
        tick();
        #1;
        chk("rc2_ph1", o_phase === 8'd1);
        chk("rc2_last_ready", o_in_ready === 1'b1);
        tick();
        #1;
        chk("rc2_done", o_integ_en === 1'b0);

        i_rate     = 8'd0;
        i_in_valid = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("r1_integ", o_integ_en === 1'b1);
            chk("r1_ready", o_in_ready === 1'b1);
            chk("r1_comb", o_comb_en === 1'b1);
            chk("r1_zero_stuff", o_zero_stuff === 1'b0);
            chk("r1_phase", o_phase === 8'd0);
            tick();
        end
        drain("r1_drain");

        tick();
        i_rate     = 8'd8;
        i_in_valid = 1'b1;
        tick();
        i_in_valid = 1'b0;
        tick();
        tick();
        #1;
        chk("r8_phase2", o_phase === 8'd2);
        chk("r8_integ_before", o_integ_en === 1'b1);
        i_in_valid = 1'b1;
        i_reset_n  = 1'b0;
        #1;
        chk("mrst_integ", o_integ_en === 1'b0);
        chk("mrst_zs", o_zero_stuff === 1'b0);
        chk("mrst_comb", o_comb_en === 1'b0);
        chk("mrst_ready", o_in_ready === 1'b0);
        chk("mrst_out_valid", o_out_valid === 1'b0);
        chk("mrst_busy", o_busy === 1'b0);
        chk("mrst_phase", o_phase === 8'd0);
        tick();
        i_reset_n = 1'b1;
        #1;
        chk("post_rst_accept", o_comb_en === 1'b1);
        tick();
        i_in_valid = 1'b0;
        #1;
        chk("post_rst_phase", o_phase === 8'd0);
        chk("post_rst_integ", o_integ_en === 1'b1);
        chk("post_rst_zs", o_zero_stuff === 1'b0);
        tick();
        #1;
        chk("post_rst_phase1", o_phase === 8'd1);
        drain("r8_drain");

`ifdef CIC_SEQ_UNDERRUN_EN
        i_reset_n = 1'b0;
        tick();
        i_reset_n = 1'b1;
        #1;
        chk("ur_clear_flag", o_underrun === 1'b0);
        chk("ur_clear_count", o_underrun_count === 16'd0);
        i_rate = 8'd2;
        for (int s = 0; s < 5; s++) begin
            i_in_valid = 1'b1;
            tick();
            i_in_valid = 1'b0;
            tick();
            tick();
            tick();
        end
        #1;
        chk("ur_flag", o_underrun === 1'b1);
        chk("ur_count", o_underrun_count === 16'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cic_interp_sequencer.md
CIC_INTERP_SEQUENCER -- requirements
Module: cic_interp_sequencer

Interface
REQ-001 SHALL have parameter RATE_WIDTH, default 8, width of the interpolation ratio and phase counter.
REQ-002 SHALL have port i_clock  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port i_rate  input  RATE_WIDTH  interpolation ratio R; value 0 treated as 1.
REQ-005 SHALL have port i_in_valid  input  1  upstream sample available.
REQ-006 SHALL have port o_in_ready  output  1  sample accepted when high with i_in_valid.
REQ-007 SHALL have port o_comb_en  output  1  comb-stage advance strobe, high exactly on the input accept cycle.
REQ-008 SHALL have port o_integ_en  output  1  integrator-chain advance strobe, drives integrator ready.
REQ-009 SHALL have port o_zero_stuff  output  1  high means the integrator input mux selects zero instead of comb output.
REQ-010 SHALL have port o_out_valid  output  1  integrator output holds a sample not yet taken downstream.
REQ-011 SHALL have port i_out_ready  input  1  downstream accepts the integrator output.
REQ-012 SHALL have port o_phase  output  RATE_WIDTH  current phase 0..R-1.
REQ-013 SHALL have port o_busy  output  1  high when state is RUN or o_out_valid is high.

Function
REQ-014 SHALL implement states IDLE (no sample in flight) and RUN (phases 0..Rl-1), where Rl is the latched ratio.
REQ-015 SHALL define slot_ok = !o_out_valid || i_out_ready; o_integ_en and o_in_ready SHALL be combinational and both require slot_ok.
REQ-016 SHALL drive o_in_ready = slot_ok && (IDLE || (RUN && phase == Rl-1)).
REQ-017 SHALL, on accept (i_in_valid && o_in_ready), assert o_comb_en, latch Rl from i_rate (0 latched as 1), enter RUN, and set phase to 0 on the next edge.
REQ-018 SHALL, in RUN with slot_ok, assert o_integ_en, with o_zero_stuff = (phase != 0).
REQ-019 SHALL, in RUN with slot_ok and phase < Rl-1, increment the phase; if slot_ok is low, the phase and state SHALL hold and o_integ_en SHALL be 0.
REQ-020 SHALL, in RUN with slot_ok at phase Rl-1, go to RUN phase 0 if a sample is accepted in the same cycle, else go to IDLE.
REQ-021 SHALL ignore i_rate changes except at the accept cycle.
REQ-022 SHALL register o_out_valid: set on o_integ_en, cleared when i_out_ready && !o_integ_en, otherwise held.
REQ-023 SHALL sustain one output per cycle under continuous input and i_out_ready high; latency SHALL be one cycle from accept to the first o_integ_en.
REQ-024 SHALL, for R=1, accept one input and produce one output per cycle with o_zero_stuff always 0.
REQ-025 SHALL drive o_zero_stuff = 0 and o_integ_en = 0 in IDLE.

Reset
REQ-026 SHALL, on i_reset_n low, asynchronously force state IDLE, phase 0, Rl = 1, and o_out_valid 0.
REQ-027 SHALL hold o_in_ready, o_comb_en, o_integ_en, o_zero_stuff, and o_busy at 0 while i_reset_n is low.
REQ-028 SHALL discard a sample in flight when reset is asserted mid-RUN, with no strobe issued after assertion.
REQ-029 SHALL, after i_reset_n deasserts, accept the first sample on the first rising edge with i_in_valid high.

Configuration
REQ-030 SHALL, with macro CIC_SEQ_UNDERRUN_EN defined, add outputs o_underrun (1 bit, sticky) and o_underrun_count (16 bits, saturating at 0xFFFF).
REQ-031 SHALL record an underrun event when RUN at phase Rl-1 fires o_integ_en without accepting a sample; the event SHALL set o_underrun and increment the count, and both SHALL clear only on reset.
REQ-032 SHALL, without CIC_SEQ_UNDERRUN_EN, omit these ports and their logic entirely, with otherwise identical behaviour.

Verification
REQ-033 SHALL verify: R=4, one sample, i_out_ready=1 -> o_comb_en at cycle t; o_integ_en at t+1..t+4; o_zero_stuff 0,1,1,1; IDLE at t+5.
REQ-034 SHALL verify: R=3, i_in_valid held high, i_out_ready=1 -> o_in_ready high at every phase 2; o_integ_en continuous with no gaps over 30 cycles.
REQ-035 SHALL verify: R=4, i_out_ready low for 3 cycles at phase 1 -> phase held at 1 and o_out_valid held at 1; on resume, phase 2 and 3 complete with no lost or duplicated strobe.
REQ-036 SHALL verify: i_rate changes from 4 to 2 mid-RUN -> the current sample completes 4 phases; the next accepted sample runs 2 phases; i_rate=0 -> behaves as R=1.
REQ-037 SHALL verify: i_reset_n pulsed low at phase 2 of R=8 -> all strobes 0 immediately; o_out_valid=0; the next sample starts at phase 0.
REQ-038 SHALL verify: with CIC_SEQ_UNDERRUN_EN, R=2, inputs spaced 4 cycles apart for 5 samples -> o_underrun=1 and o_underrun_count=5.
